// File: rtl/ssd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ssd_pkg
// Description : Shared constants, segment table, overflow helper and FSM
//               state type for the multi-digit seven-segment controller.
// Revision    : 1.0 - initial release
// ============================================================================
package ssd_pkg;

    // Active-low segment patterns, bit6 = g .. bit0 = a
    localparam logic [6:0] SSD_BLANK = 7'b1111111;
    localparam logic [6:0] SSD_DASH  = 7'b0111111;

    // Nibble 0..F to active-low segments (lower-case b and d)
    localparam logic [6:0] SSD_HEX_TABLE [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_UPDATE  = 2'd2
    } ssd_state_e;

    // 10^n, used as the decimal overflow threshold
    function automatic logic [31:0] pow10(input int n);
        logic [31:0] r;
        r = 32'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 32'd10;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ssd_bin2bcd.sv
`default_nettype none
// ============================================================================
// Module      : ssd_bin2bcd
// Description : Iterative double-dabble converter. One shift per clock,
//               DATA_W shifts per conversion. done_o is high during the
//               cycle whose edge performs the final shift, so bcd_o holds
//               the finished result from the following cycle onward.
// Revision    : 1.0 - initial release
// ============================================================================
module ssd_bin2bcd #(
    parameter int DATA_W     = 14,
    parameter int NUM_DIGITS = 4
)(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start_i,
    input  logic [DATA_W-1:0]       data_i,
    output logic                    done_o,
    output logic [4*NUM_DIGITS-1:0] bcd_o
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic [DATA_W-1:0] bin_q;
    logic [BCD_W-1:0]  bcd_q;
    logic [BCD_W-1:0]  bcd_adj_w;
    logic [CNT_W-1:0]  cnt_q;
    logic              run_q;

    // Add-3 correction on every BCD nibble that is 5 or more
    always_comb begin
        bcd_adj_w = bcd_q;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5) begin
                bcd_adj_w[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
            end
        end
    end

    assign done_o = run_q && (cnt_q == CNT_W'(DATA_W - 1));
    assign bcd_o  = bcd_q;

    // Load on start, then shift the corrected BCD/binary pair left once per clock
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bin_q <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (start_i) begin
            bin_q <= data_i;
            bcd_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b1;
        end else if (run_q) begin
            bcd_q <= BCD_W'({bcd_adj_w, bin_q[DATA_W-1]});
            bin_q <= bin_q << 1;
            cnt_q <= cnt_q + 1'b1;
            if (done_o) begin
                run_q <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ssd_multi_display.sv
`default_nettype none
// ============================================================================
// Module      : ssd_multi_display
// Description : Multi-digit seven-segment controller with valid/ready input,
//               hex or decimal display, leading-zero blanking, overflow dashes
//               and a combinational enable mask.
//               Optional macro SSD_BLINK_EN adds a blink input and a
//               free-running BLINK_DIV-bit blink counter.
// Revision    : 1.0 - initial release
// ============================================================================
module ssd_multi_display
    import ssd_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DATA_W     = 14
`ifdef SSD_BLINK_EN
    ,
    parameter int BLINK_DIV  = 24
`endif
)(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
`ifdef SSD_BLINK_EN
    input  logic                    blink,
`endif
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       data_in,
    input  logic                    dec_mode,
    input  logic                    blank_lz,
    output logic                    busy,
    output logic [7*NUM_DIGITS-1:0] ssdout
);

    localparam int          BCD_W     = 4 * NUM_DIGITS;
    localparam logic [31:0] DEC_LIMIT = pow10(NUM_DIGITS);
    localparam logic [31:0] HEX_LIMIT = 32'd1 << BCD_W;

    ssd_state_e              state_q;
    logic                    in_ready_q;
    logic [DATA_W-1:0]       data_q;
    logic                    dec_q;
    logic                    blz_q;
    logic                    ovf_q;
    logic [7*NUM_DIGITS-1:0] seg_q;
    logic [7*NUM_DIGITS-1:0] seg_d;
    logic [BCD_W-1:0]        bcd_w;
    logic [BCD_W-1:0]        val_w;
    logic                    start_w;
    logic                    conv_done_w;
    logic                    blink_off_w;

    assign start_w = (state_q == ST_IDLE) && in_valid && dec_mode;

    ssd_bin2bcd #(
        .DATA_W     (DATA_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_bin2bcd (
        .clk     (clk),
        .reset   (reset),
        .start_i (start_w),
        .data_i  (data_in),
        .done_o  (conv_done_w),
        .bcd_o   (bcd_w)
    );

    assign val_w = dec_q ? bcd_w : BCD_W'(data_q);

    // Next digit patterns: decode, blank above the top nonzero digit, dash on overflow
    always_comb begin
        logic       seen;
        logic [3:0] nib;
        seg_d = '0;
        seen  = 1'b0;
        nib   = 4'd0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            nib = val_w[4*k +: 4];
            if ((nib != 4'd0) || (k == 0)) begin
                seen = 1'b1;
            end
            seg_d[7*k +: 7] = (blz_q && !seen) ? SSD_BLANK : SSD_HEX_TABLE[nib];
        end
        if (ovf_q) begin
            seg_d = {NUM_DIGITS{SSD_DASH}};
        end
    end

    // Control FSM: capture on transfer, wait for conversion, commit digits in one edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            in_ready_q <= 1'b1;
            data_q     <= '0;
            dec_q      <= 1'b0;
            blz_q      <= 1'b0;
            ovf_q      <= 1'b0;
            seg_q      <= {NUM_DIGITS{SSD_BLANK}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        data_q     <= data_in;
                        dec_q      <= dec_mode;
                        blz_q      <= blank_lz;
                        ovf_q      <= dec_mode ? (32'(data_in) >= DEC_LIMIT)
                                               : (32'(data_in) >= HEX_LIMIT);
                        in_ready_q <= 1'b0;
                        state_q    <= dec_mode ? ST_CONVERT : ST_UPDATE;
                    end
                end
                ST_CONVERT: begin
                    if (conv_done_w) begin
                        state_q <= ST_UPDATE;
                    end
                end
                ST_UPDATE: begin
                    seg_q      <= seg_d;
                    in_ready_q <= 1'b1;
                    state_q    <= ST_IDLE;
                end
                default: begin
                    state_q    <= ST_IDLE;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

`ifdef SSD_BLINK_EN
    logic [BLINK_DIV-1:0] blink_cnt_q;

    // Free-running blink timebase, independent of blink and en
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt_q <= '0;
        end else begin
            blink_cnt_q <= blink_cnt_q + 1'b1;
        end
    end

    assign blink_off_w = blink && blink_cnt_q[BLINK_DIV-1];
`else
    assign blink_off_w = 1'b0;
`endif

    assign in_ready = in_ready_q;
    assign busy     = !in_ready_q;
    assign ssdout   = (!en || blink_off_w) ? {NUM_DIGITS{SSD_BLANK}} : seg_q;

endmodule
`default_nettype wire

// File: tb/tb_ssd_multi_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_ssd_multi_display
// Description : Directed self-checking bench for ssd_multi_display with a
//               4-digit and a 3-digit instance sharing the same stimulus.
//               Blink checks are present when SSD_BLINK_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ssd_multi_display;

    localparam logic [6:0] S_B = 7'b1111111;
    localparam logic [6:0] S_D = 7'b0111111;
    localparam logic [6:0] S_0 = 7'b1000000;
    localparam logic [6:0] S_1 = 7'b1111001;
    localparam logic [6:0] S_2 = 7'b0100100;
    localparam logic [6:0] S_3 = 7'b0110000;
    localparam logic [6:0] S_4 = 7'b0011001;
    localparam logic [6:0] S_9 = 7'b0011000;
    localparam logic [6:0] S_A = 7'b0001000;
    localparam logic [6:0] S_b = 7'b0000011;
    localparam logic [6:0] S_F = 7'b0001110;

    localparam logic [27:0] ALL_B4 = {S_B, S_B, S_B, S_B};
    localparam logic [20:0] ALL_B3 = {S_B, S_B, S_B};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b1;
    logic        blink = 1'b0;
    logic        in_valid = 1'b0;
    logic [13:0] data_in = '0;
    logic        dec_mode = 1'b0;
    logic        blank_lz = 1'b0;
    logic        in_ready, busy, in_ready3, busy3;
    logic [27:0] ssdout;
    logic [20:0] ssdout3;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ssd_multi_display #(
        .NUM_DIGITS (4),
        .DATA_W     (14)
`ifdef SSD_BLINK_EN
        ,
        .BLINK_DIV  (3)
`endif
    ) u_dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
`ifdef SSD_BLINK_EN
        .blink    (blink),
`endif
        .in_valid (in_valid),
        .in_ready (in_ready),
        .data_in  (data_in),
        .dec_mode (dec_mode),
        .blank_lz (blank_lz),
        .busy     (busy),
        .ssdout   (ssdout)
    );

    ssd_multi_display #(
        .NUM_DIGITS (3),
        .DATA_W     (14)
`ifdef SSD_BLINK_EN
        ,
        .BLINK_DIV  (3)
`endif
    ) u_dut3 (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
`ifdef SSD_BLINK_EN
        .blink    (blink),
`endif
        .in_valid (in_valid),
        .in_ready (in_ready3),
        .data_in  (data_in),
        .dec_mode (dec_mode),
        .blank_lz (blank_lz),
        .busy     (busy3),
        .ssdout   (ssdout3)
    );

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One transfer, then count cycles until in_ready returns (bounded)
    task automatic xfer(input logic [13:0] d, input logic dm, input logic bl, output int lat);
        @(negedge clk);
        data_in  = d;
        dec_mode = dm;
        blank_lz = bl;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!in_ready && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        int  lat;
        int  blanks;
        logic bad;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_value("rst_ssdout", ssdout, ALL_B4);
        check_value("rst_ready", in_ready, 1);
        check_value("rst_busy", busy, 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_value("post_rst_ssdout", ssdout, ALL_B4);
        check_value("post_rst_ready", in_ready, 1);

        // Hex 1A3F
        xfer(14'h1A3F, 1'b0, 1'b0, lat);
        check_value("hex_1A3F_lat", lat, 1);
        check_value("hex_1A3F_seg", ssdout, {S_1, S_A, S_3, S_F});
        check_value("hex_1A3F_nd3_ovf", ssdout3, {S_D, S_D, S_D});

        // Decimal 1234 with an ignored 9999 request at E3
        @(negedge clk);
        data_in  = 14'd1234;
        dec_mode = 1'b1;
        blank_lz = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_value("dec_busy_e0", busy, 1);
        for (int i = 0; i <= 15; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            if (i == 2) begin
                data_in  = 14'd9999;
                in_valid = 1'b1;
            end
            if (i == 3) in_valid = 1'b0;
            if (i < 15) begin
                check_value("dec_ready_low", in_ready, 0);
                check_value("dec_hold_prev", ssdout, {S_1, S_A, S_3, S_F});
            end else begin
                check_value("dec_ready_back", in_ready, 1);
                check_value("dec_1234_seg", ssdout, {S_1, S_2, S_3, S_4});
            end
        end
        repeat (20) @(posedge clk);
        #1;
        check_value("dec_9999_ignored", ssdout, {S_1, S_2, S_3, S_4});
        check_value("dec_idle_ready", in_ready, 1);

        // Largest in-range decimal
        xfer(14'd9999, 1'b1, 1'b0, lat);
        check_value("dec_9999_lat", lat, 15);
        check_value("dec_9999_seg", ssdout, {S_9, S_9, S_9, S_9});

        // Leading-zero blanking
        xfer(14'd42, 1'b1, 1'b1, lat);
        check_value("dec_42_blz", ssdout, {S_B, S_B, S_4, S_2});
        check_value("dec_42_blz_nd3", ssdout3, {S_B, S_4, S_2});
        xfer(14'd0, 1'b1, 1'b1, lat);
        check_value("dec_0_blz", ssdout, {S_B, S_B, S_B, S_0});

        // Overflow
        xfer(14'd10000, 1'b1, 1'b1, lat);
        check_value("dec_10000_ovf", ssdout, {S_D, S_D, S_D, S_D});
        check_value("dec_10000_ovf_nd3", ssdout3, {S_D, S_D, S_D});
        xfer(14'h3FFF, 1'b0, 1'b0, lat);
        check_value("hex_3FFF_nd4", ssdout, {S_3, S_F, S_F, S_F});
        check_value("hex_3FFF_nd3_ovf", ssdout3, {S_D, S_D, S_D});
        xfer(14'h0FFF, 1'b0, 1'b0, lat);
        check_value("hex_0FFF_nd3", ssdout3, {S_F, S_F, S_F});
        check_value("hex_0FFF_nd4", ssdout, {S_0, S_F, S_F, S_F});

        // Enable mask
        xfer(14'h00AB, 1'b0, 1'b0, lat);
        check_value("hex_00AB_seg", ssdout, {S_0, S_0, S_A, S_b});
        @(negedge clk);
        en = 1'b0;
        #1;
        check_value("en0_blank", ssdout, ALL_B4);
        check_value("en0_blank_nd3", ssdout3, ALL_B3);
        @(negedge clk);
        en = 1'b1;
        #1;
        check_value("en1_restore", ssdout, {S_0, S_0, S_A, S_b});

        // Reset five cycles into a decimal conversion
        @(negedge clk);
        data_in  = 14'd1234;
        dec_mode = 1'b1;
        blank_lz = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_value("abort_blank", ssdout, ALL_B4);
        check_value("abort_ready", in_ready, 1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        bad = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (ssdout !== ALL_B4) bad = 1'b1;
        end
        check_value("abort_no_partial", bad, 0);
        check_value("abort_ready_after", in_ready, 1);

`ifdef SSD_BLINK_EN
        xfer(14'h00AB, 1'b0, 1'b0, lat);
        @(negedge clk);
        blink = 1'b1;
        blanks = 0;
        repeat (16) begin
            @(posedge clk);
            #1;
            if (ssdout === ALL_B4) blanks++;
        end
        check_value("blink_blank_count", blanks, 8);
        blink = 1'b0;
        @(posedge clk);
        #1;
        check_value("blink_off_restore", ssdout, {S_0, S_0, S_A, S_b});
`else
        blanks = 0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
